// File: rtl/pf_iod_ctrl_out_lanes.sv
// Gearboxed DDR4 control-pin output lanes with a shared delay-line tap sequencer.
// Optional CTRL_OUT_PIPE_EN adds a second register stage on TX_DATA_OUT/OE_DATA_OUT.
module pf_iod_ctrl_out_lanes #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned GEAR      = 4,
    parameter int unsigned LANE_W    = 2,
    parameter int unsigned TAP_W     = 8,
    parameter int unsigned MOVE_GAP  = 2
) (
    input  logic                      FAB_CLK,
    input  logic                      SYNC_RST_N,
    input  logic [NUM_LANES*GEAR-1:0] TX_DATA_IN,
    input  logic [NUM_LANES-1:0]      OE_IN,
    output logic [NUM_LANES*GEAR-1:0] TX_DATA_OUT,
    output logic [NUM_LANES*GEAR-1:0] OE_DATA_OUT,
    input  logic                      TAP_REQ_VALID,
    output logic                      TAP_REQ_READY,
    input  logic [LANE_W-1:0]         TAP_REQ_LANE,
    input  logic [TAP_W-1:0]          TAP_REQ_VALUE,
    input  logic                      TAP_REQ_RELOAD,
    output logic [NUM_LANES-1:0]      DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]      DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]      DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0]      DELAY_LINE_OUT_OF_RANGE,
    output logic                      TAP_DONE,
    output logic                      TAP_ERR,
    output logic [TAP_W-1:0]          TAP_STATUS
);

    localparam int unsigned GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MOVE = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [NUM_LANES*GEAR-1:0] tx_q, oe_q, oe_rep;

    always_comb begin
        oe_rep = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            oe_rep[l*GEAR +: GEAR] = {GEAR{OE_IN[l]}};
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (!SYNC_RST_N) begin
            tx_q <= '0;
            oe_q <= '0;
        end else begin
            tx_q <= TX_DATA_IN;
            oe_q <= oe_rep;
        end
    end

`ifdef CTRL_OUT_PIPE_EN
    logic [NUM_LANES*GEAR-1:0] tx2_q, oe2_q;

    always_ff @(posedge FAB_CLK) begin
        if (!SYNC_RST_N) begin
            tx2_q <= '0;
            oe2_q <= '0;
        end else begin
            tx2_q <= tx_q;
            oe2_q <= oe_q;
        end
    end

    assign TX_DATA_OUT = tx2_q;
    assign OE_DATA_OUT = oe2_q;
`else
    assign TX_DATA_OUT = tx_q;
    assign OE_DATA_OUT = oe_q;
`endif

    logic [2:0]           state_q, state_d;
    logic                 ready_q;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [TAP_W-1:0]     tgt_q, tgt_d;
    logic                 dir_q, dir_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [TAP_W-1:0]     status_q;
    logic [TAP_W-1:0]     cur_q [NUM_LANES];
    logic [NUM_LANES-1:0] lane_oh;
    logic [TAP_W-1:0]     cap_cur, req_cur, cur_wval;
    logic                 req_lane_ok, cur_we, oor_sel;

    // Lane muxes are built by comparison so an out-of-range index never addresses cur_q.
    always_comb begin
        lane_oh     = '0;
        cap_cur     = '0;
        req_cur     = '0;
        req_lane_ok = 1'b0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if ({1'b0, lane_q} == (LANE_W+1)'(l)) begin
                lane_oh[l] = 1'b1;
                cap_cur    = cur_q[l];
            end
            if ({1'b0, TAP_REQ_LANE} == (LANE_W+1)'(l)) begin
                req_lane_ok = 1'b1;
                req_cur     = cur_q[l];
            end
        end
    end

    assign oor_sel = |(DELAY_LINE_OUT_OF_RANGE & lane_oh);

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        tgt_d    = tgt_q;
        dir_d    = dir_q;
        gap_d    = gap_q;
        cur_we   = 1'b0;
        cur_wval = cap_cur;
        case (state_q)
            S_IDLE: begin
                if (TAP_REQ_VALID && ready_q) begin
                    lane_d = TAP_REQ_LANE;
                    tgt_d  = TAP_REQ_VALUE;
                    if (!req_lane_ok) begin
                        state_d = S_ERR;
                    end else if (TAP_REQ_RELOAD) begin
                        state_d = S_LOAD;
                    end else if (TAP_REQ_VALUE != req_cur) begin
                        state_d = S_MOVE;
                        dir_d   = (TAP_REQ_VALUE > req_cur);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                cur_we   = 1'b1;
                cur_wval = '0;
                if (tgt_q != '0) begin
                    state_d = S_MOVE;
                    dir_d   = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_MOVE: begin
                state_d = S_GAP;
                gap_d   = GAP_W'(MOVE_GAP - 1);
            end
            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (oor_sel) begin
                    state_d = S_ERR;
                end else begin
                    cur_we   = 1'b1;
                    cur_wval = dir_q ? cap_cur + TAP_W'(1) : cap_cur - TAP_W'(1);
                    state_d  = (cur_wval != tgt_q) ? S_MOVE : S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (!SYNC_RST_N) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            lane_q   <= '0;
            tgt_q    <= '0;
            dir_q    <= 1'b0;
            gap_q    <= '0;
            status_q <= '0;
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                cur_q[l] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ready_q  <= (state_d == S_IDLE);
            lane_q   <= lane_d;
            tgt_q    <= tgt_d;
            dir_q    <= dir_d;
            gap_q    <= gap_d;
            status_q <= (|lane_oh) ? cap_cur : status_q;
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                if (cur_we && lane_oh[l]) begin
                    cur_q[l] <= cur_wval;
                end
            end
        end
    end

    assign TAP_REQ_READY        = ready_q;
    assign DELAY_LINE_LOAD      = (state_q == S_LOAD) ? lane_oh : '0;
    assign DELAY_LINE_MOVE      = (state_q == S_MOVE) ? lane_oh : '0;
    assign DELAY_LINE_DIRECTION = ((state_q == S_MOVE || state_q == S_GAP) && dir_q) ? lane_oh : '0;
    assign TAP_DONE             = (state_q == S_DONE);
    assign TAP_ERR              = (state_q == S_ERR);
    assign TAP_STATUS           = status_q;

endmodule

// File: tb/tb_pf_iod_ctrl_out_lanes.sv
// Bench for pf_iod_ctrl_out_lanes: data-path vector table plus tap-sequencer scoreboard.
module tb_pf_iod_ctrl_out_lanes;

    localparam int unsigned NL = 4;
    localparam int unsigned G  = 4;
    localparam int unsigned LW = 3;
    localparam int unsigned TW = 8;
    localparam int unsigned MG = 2;
`ifdef CTRL_OUT_PIPE_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NL*G-1:0] tx_in, tx_out, oe_out;
    logic [NL-1:0]   oe_in;
    logic            req_valid, req_ready, req_reload;
    logic [LW-1:0]   req_lane;
    logic [TW-1:0]   req_value;
    logic [NL-1:0]   dl_load, dl_move, dl_dir, dl_oor;
    logic            tap_done, tap_err;
    logic [TW-1:0]   tap_status;

    always #5 clk = ~clk;

    pf_iod_ctrl_out_lanes #(
        .NUM_LANES(NL), .GEAR(G), .LANE_W(LW), .TAP_W(TW), .MOVE_GAP(MG)
    ) dut (
        .FAB_CLK(clk),
        .SYNC_RST_N(rst_n),
        .TX_DATA_IN(tx_in),
        .OE_IN(oe_in),
        .TX_DATA_OUT(tx_out),
        .OE_DATA_OUT(oe_out),
        .TAP_REQ_VALID(req_valid),
        .TAP_REQ_READY(req_ready),
        .TAP_REQ_LANE(req_lane),
        .TAP_REQ_VALUE(req_value),
        .TAP_REQ_RELOAD(req_reload),
        .DELAY_LINE_LOAD(dl_load),
        .DELAY_LINE_MOVE(dl_move),
        .DELAY_LINE_DIRECTION(dl_dir),
        .DELAY_LINE_OUT_OF_RANGE(dl_oor),
        .TAP_DONE(tap_done),
        .TAP_ERR(tap_err),
        .TAP_STATUS(tap_status)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] tx;
        logic [3:0]  oe;
        logic [15:0] etx;
        logic [15:0] eoe;
    } dvec_t;

    typedef struct {
        logic [15:0] etx;
        logic [15:0] eoe;
    } dexp_t;

    typedef struct {
        bit is_err;
        int loads;
        int moves;
    } tap_exp_t;

    dvec_t    dv[8];
    dexp_t    dq[$];
    tap_exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_req(input string name, input int lane, input int val, input bit rld,
                           input int oor_at, input bit exp_err, input int exp_loads,
                           input int exp_moves, input bit exp_dir, input bit chk_stat,
                           input int exp_stat);
        tap_exp_t  e;
        int        w, cyc, loads, moves, bad, dirbad, spbad, last_mv;
        bit        fin, saw_err;
        logic [3:0] oh;
        oh = (lane < NL) ? (4'b0001 << lane) : 4'b0000;
        loads = 0; moves = 0; bad = 0; dirbad = 0; spbad = 0; last_mv = 0;
        fin = 1'b0; saw_err = 1'b0;
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_ready_before"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_lane   = LW'(lane);
        req_value  = TW'(val);
        req_reload = rld;
        e.is_err = exp_err;
        e.loads  = exp_loads;
        e.moves  = exp_moves;
        sb.push_back(e);
        @(negedge clk);
        // keep VALID high with a different request while busy; it must be ignored
        req_lane   = '0;
        req_value  = 8'hC8;
        req_reload = 1'b1;
        chk({name, "_ready_drop"}, 32'(req_ready), 32'd0);
        for (cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (|(dl_load & ~oh) || |(dl_move & ~oh)) bad++;
            if (|(dl_load & oh)) loads++;
            if (tap_done || tap_err) begin
                fin       = 1'b1;
                saw_err   = tap_err;
                req_valid = 1'b0;
            end else begin
                if (moves > 0 || |(dl_move & oh)) begin
                    if (dl_dir !== (exp_dir ? oh : 4'b0000)) dirbad++;
                end
                if (|(dl_move & oh)) begin
                    if (moves > 0 && (cyc - last_mv) != int'(MG + 1)) spbad++;
                    last_mv = cyc;
                    moves++;
                    if (moves == oor_at) dl_oor[lane] = 1'b1;
                end
                @(negedge clk);
            end
        end
        req_valid  = 1'b0;
        req_reload = 1'b0;
        dl_oor     = '0;
        chk({name, "_finished"}, 32'(fin), 32'd1);
        e = sb.pop_front();
        chk({name, "_err_flag"}, 32'(saw_err), 32'(e.is_err));
        chk({name, "_loads"}, 32'(loads), 32'(e.loads));
        chk({name, "_moves"}, 32'(moves), 32'(e.moves));
        chk({name, "_wrong_lane"}, 32'(bad), 32'd0);
        chk({name, "_direction"}, 32'(dirbad), 32'd0);
        chk({name, "_spacing"}, 32'(spbad), 32'd0);
        @(negedge clk);
        if (chk_stat) chk({name, "_status"}, 32'(tap_status), 32'(exp_stat));
        chk({name, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int   w;
        bit   saw;
        dexp_t d;

        dv[0] = '{16'h000A, 4'b0101, 16'h000A, 16'h0F0F};
        dv[1] = '{16'hFFFF, 4'b1111, 16'hFFFF, 16'hFFFF};
        dv[2] = '{16'h1234, 4'b1000, 16'h1234, 16'hF000};
        dv[3] = '{16'h0000, 4'b0010, 16'h0000, 16'h00F0};
        dv[4] = '{16'hA5C3, 4'b0110, 16'hA5C3, 16'h0FF0};
        dv[5] = '{16'h8001, 4'b0000, 16'h8001, 16'h0000};
        dv[6] = '{16'h5A5A, 4'b1001, 16'h5A5A, 16'hF00F};
        dv[7] = '{16'hC33C, 4'b0100, 16'hC33C, 16'h0F00};

        rst_n      = 1'b0;
        tx_in      = '1;
        oe_in      = '1;
        req_valid  = 1'b0;
        req_lane   = '0;
        req_value  = '0;
        req_reload = 1'b0;
        dl_oor     = '0;

        repeat (3) @(negedge clk);
        chk("rst_tx_out", 32'(tx_out), 32'd0);
        chk("rst_oe_out", 32'(oe_out), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_pulses", 32'({dl_load, dl_move, dl_dir, tap_done, tap_err}), 32'd0);
        chk("rst_status", 32'(tap_status), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            if (dq.size() >= LAT) begin
                d = dq.pop_front();
                chk($sformatf("tx_vec%0d", i - int'(LAT)), 32'(tx_out), 32'(d.etx));
                chk($sformatf("oe_vec%0d", i - int'(LAT)), 32'(oe_out), 32'(d.eoe));
            end
            tx_in = dv[i].tx;
            oe_in = dv[i].oe;
            d.etx = dv[i].etx;
            d.eoe = dv[i].eoe;
            dq.push_back(d);
            @(negedge clk);
        end
        for (int i = 0; i < int'(LAT); i++) begin
            d = dq.pop_front();
            chk($sformatf("tx_drain%0d", i), 32'(tx_out), 32'(d.etx));
            chk($sformatf("oe_drain%0d", i), 32'(oe_out), 32'(d.eoe));
            @(negedge clk);
        end

        run_req("l2_up5",    2, 5, 1'b0, 0, 1'b0, 0, 5, 1'b1, 1'b1, 5);
        run_req("l2_dn3",    2, 3, 1'b0, 0, 1'b0, 0, 2, 1'b0, 1'b1, 3);
        run_req("l2_same3",  2, 3, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 3);
        run_req("l0_rld2",   0, 2, 1'b1, 0, 1'b0, 1, 2, 1'b1, 1'b1, 2);
        run_req("lane5_bad", 5, 7, 1'b0, 0, 1'b1, 0, 0, 1'b0, 1'b0, 0);
        run_req("l2_rld0",   2, 0, 1'b1, 0, 1'b0, 1, 0, 1'b0, 1'b1, 0);
        run_req("l1_oor",    1, 6, 1'b0, 3, 1'b1, 0, 3, 1'b1, 1'b1, 2);

        // Reset in the middle of a move sequence on lane 3
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        req_lane  = 3'd3;
        req_value = 8'd10;
        @(negedge clk);
        req_valid = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 50 && !saw; i++) begin
            if (dl_move[3]) saw = 1'b1;
            else @(negedge clk);
        end
        chk("midrst_move_seen", 32'(saw), 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_pulses", 32'({dl_load, dl_move, dl_dir, tap_done, tap_err}), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_status", 32'(tap_status), 32'd0);
        chk("midrst_tx_out", 32'(tx_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_pulse", 32'({tap_done, tap_err}), 32'd0);
        run_req("l3_post_rst", 3, 1, 1'b0, 0, 1'b0, 0, 1, 1'b1, 1'b1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
